// File: rtl/row_fetch_server_if.sv
// rtl/row_fetch_server_if.sv - request, pixel-memory and response channels of row_fetch_server
interface row_fetch_server_if #(
   parameter int PIX_W   = 8,
   parameter int ROW_PIX = 15,
   parameter int IDX_W   = 16,
   parameter int ADDR_W  = 20
);
   logic                     req_valid;
   logic                     req_ready;
   logic [IDX_W-1:0]         req_row;
   logic                     mem_rd_en;
   logic [ADDR_W-1:0]        mem_addr;
   logic [PIX_W-1:0]         mem_rd_data;
   logic                     row_valid;
   logic                     row_ready;
   logic [PIX_W*ROW_PIX-1:0] row_data;
   logic [IDX_W-1:0]         row_idx;
   logic                     row_err;
   logic                     busy;

   modport master (
      output req_valid, req_row, mem_rd_data, row_ready,
      input  req_ready, mem_rd_en, mem_addr, row_valid, row_data, row_idx, row_err, busy
   );

   modport slave (
      input  req_valid, req_row, mem_rd_data, row_ready,
      output req_ready, mem_rd_en, mem_addr, row_valid, row_data, row_idx, row_err, busy
   );
endinterface

// File: rtl/row_fetch_server.sv
// rtl/row_fetch_server.sv - fetches one 15-pixel row per request from byte memory and packs it MSB-first
// Optional one-entry row cache enabled by defining ROW_CACHE_EN.
module row_fetch_server #(
   parameter int PIX_W    = 8,
   parameter int ROW_PIX  = 15,
   parameter int IDX_W    = 16,
   parameter int ADDR_W   = 20,
   parameter int NUM_ROWS = 28800
) (
   input  logic              clk,
   input  logic              rst,
   row_fetch_server_if.slave bus
);
   localparam int                 ROW_W    = PIX_W * ROW_PIX;
   localparam logic [3:0]         K_LAST   = 4'(ROW_PIX - 1);
   localparam logic [IDX_W-1:0]   LAST_ROW = IDX_W'(NUM_ROWS - 1);

   typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [3:0]        k_q;
   logic [3:0]        rd_k_q;
   logic              rd_pending_q;
   logic [ROW_W-1:0]  pack_q;
   logic [IDX_W-1:0]  row_idx_q;
   logic              row_err_q;
   logic              in_range;
   logic              cache_hit;
   logic              accept;
   logic              handshake;
   logic              rd_en;
   logic              req_ready;
   logic [ADDR_W-1:0] row_base;

   assign in_range = (bus.req_row <= LAST_ROW);
   assign row_base = (ADDR_W'(bus.req_row) << 4) - ADDR_W'(bus.req_row);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rd_en     = 1'b0;
      accept    = 1'b0;
      handshake = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               accept  = 1'b1;
               state_d = (!in_range || cache_hit) ? OUT : READ;
            end
         end
         READ: begin
            rd_en = 1'b1;
            if (k_q == K_LAST) state_d = WAIT;
         end
         WAIT: state_d = OUT;
         OUT: begin
            if (bus.row_ready) begin
               handshake = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // rd_pending/rd_k follow the strobe by one cycle so each byte lands in its slot on return.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q       <= '0;
         k_q          <= '0;
         rd_k_q       <= '0;
         rd_pending_q <= 1'b0;
         pack_q       <= '0;
         row_idx_q    <= '0;
         row_err_q    <= 1'b0;
      end else begin
         rd_pending_q <= rd_en;
         rd_k_q       <= k_q;
         if (rd_pending_q) begin
            for (int i = 0; i < ROW_PIX; i++) begin
               if (rd_k_q == 4'(i)) pack_q[ROW_W-PIX_W*(i+1) +: PIX_W] <= bus.mem_rd_data;
            end
         end
         if (accept) begin
            base_q    <= row_base;
            k_q       <= '0;
            row_idx_q <= bus.req_row;
            row_err_q <= !in_range;
         end else begin
            if (rd_en) k_q <= k_q + 4'd1;
            if (handshake) row_err_q <= 1'b0;
         end
      end
   end

`ifdef ROW_CACHE_EN
   logic [IDX_W-1:0] cache_idx_q;
   logic             cache_vld_q;

   // pack_q doubles as the cached row: error rows only mask the output, never overwrite it.
   assign cache_hit = cache_vld_q && (bus.req_row == cache_idx_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cache_vld_q <= 1'b0;
         cache_idx_q <= '0;
      end else if (handshake && !row_err_q) begin
         cache_vld_q <= 1'b1;
         cache_idx_q <= row_idx_q;
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   assign bus.req_ready = req_ready;
   assign bus.mem_rd_en = rd_en;
   assign bus.mem_addr  = rd_en ? (base_q + ADDR_W'(k_q)) : '0;
   assign bus.row_valid = (state_q == OUT);
   assign bus.row_data  = row_err_q ? '0 : pack_q;
   assign bus.row_idx   = row_idx_q;
   assign bus.row_err   = row_err_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_row_fetch_server.sv
// tb/tb_row_fetch_server.sv - randomized self-checking bench for row_fetch_server against a row-level model
module tb_row_fetch_server;
`ifdef ROW_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   localparam int NUM_ROWS = 28800;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   addr_idle_bad = 0;
   logic [19:0] rd_addr_q[$];
   int          rd_cyc_q[$];
   bit          mc_valid;
   logic [15:0] mc_idx;
   bit          prev_b2b;
   int          prev_acc;
   int          prev_period;

   row_fetch_server_if bus ();

   row_fetch_server dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem_byte(input logic [19:0] a);
      return a[7:0] ^ {a[11:8], a[19:16]};
   endfunction

   // Byte memory with one-cycle read latency; garbage whenever no read was issued.
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= mem_byte(bus.mem_addr);
      else               bus.mem_rd_data <= 8'($urandom);
   end

   always @(negedge clk) begin
      if (bus.mem_rd_en) begin
         rd_addr_q.push_back(bus.mem_addr);
         rd_cyc_q.push_back(cyc);
      end else if (bus.mem_addr != 20'd0) begin
         addr_idle_bad++;
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_ctrl", {bus.req_ready, bus.row_valid, bus.row_err, bus.busy, bus.mem_rd_en}, 5'b10000);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_data", bus.row_data, 0);
      check("rst_idx", bus.row_idx, 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b1;
      mc_valid = 1'b0;
      prev_b2b = 1'b0;
   endtask

   // One full request/response; entered and left on a falling edge.
   task automatic fetch(input logic [15:0] row, input int hold, input bit b2b, input logic [15:0] nrow);
      bit          err, hit;
      int          n, lat, acc, start, bad, unstable;
      logic [19:0] base;
      logic [119:0] exp_data, snap_d;
      logic [15:0] snap_i;
      err  = (int'(row) >= NUM_ROWS);
      hit  = CACHE && !err && mc_valid && (row == mc_idx);
      base = 20'(row) * 20'd15;
      exp_data = '0;
      if (!err) for (int i = 0; i < 15; i++) exp_data = {exp_data[111:0], mem_byte(base + 20'(i))};

      bus.req_row   = row;
      bus.req_valid = 1'b1;
      bus.row_ready = 1'b0;
      n = 0;
      while (!bus.req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", n < 40, 1'b1);
      start = rd_addr_q.size();
      @(posedge clk);
      #1;
      acc = cyc;
      if (b2b) bus.req_row = nrow;
      else     bus.req_valid = 1'b0;
      if (prev_b2b) check("b2b_period", acc - prev_acc, prev_period);

      lat = 0;
      bad = 0;
      forever begin
         @(negedge clk);
         if (bus.row_valid || lat >= 40) break;
         if (bus.req_ready) bad++;
         @(posedge clk);
         lat++;
      end
      check("busy_req_ready", bad, 0);
      check("lat_edges", lat, (err || hit) ? 0 : 16);
      check("row_data", bus.row_data, exp_data);
      check("row_idx", bus.row_idx, row);
      check("row_err", bus.row_err, err);
      check("rd_count", rd_addr_q.size() - start, (err || hit) ? 0 : 15);
      bad = 0;
      for (int i = start; i < rd_addr_q.size(); i++) begin
         if (rd_addr_q[i] != base + 20'(i - start) || rd_cyc_q[i] != acc + (i - start)) bad++;
      end
      check("rd_seq", bad, 0);

      snap_d = bus.row_data;
      snap_i = bus.row_idx;
      unstable = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (!bus.row_valid || bus.row_data !== snap_d || bus.row_idx !== snap_i || bus.req_ready) unstable++;
      end
      check("hold_stable", unstable, 0);

      bus.row_ready = 1'b1;
      @(negedge clk);
      check("post_handshake", {bus.row_valid, bus.row_err, bus.busy, bus.req_ready}, 4'b0001);
      bus.row_ready = 1'b0;
      if (!err) begin
         mc_valid = 1'b1;
         mc_idx   = row;
      end
      prev_acc    = acc;
      prev_b2b    = b2b;
      prev_period = ((err || hit) ? 0 : 16) + hold + 2;
   endtask

   task automatic mid_reset(input logic [15:0] row);
      int n, start;
      bus.req_row   = row;
      bus.req_valid = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      start = rd_addr_q.size();
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      n = 0;
      while (rd_addr_q.size() - start < 8 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("reads_before_reset", rd_addr_q.size() - start, 8);
      do_reset();
   endtask

   initial begin
      logic [15:0] cur, nxt;
      int          r;
      rst = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_row   = '0;
      bus.row_ready = 1'b0;
      mc_valid = 1'b0;
      mc_idx   = '0;
      prev_b2b = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b1;
      @(negedge clk);

      fetch(16'd0, 0, 1'b0, 16'd0);
      fetch(16'd28799, 0, 1'b0, 16'd0);
      fetch(16'd28800, 0, 1'b0, 16'd0);
      fetch(16'd65535, 0, 1'b1, 16'd17);
      fetch(16'd17, 10, 1'b1, 16'd9);
      fetch(16'd9, 0, 1'b0, 16'd0);
      fetch(16'd3, 0, 1'b1, 16'd3);
      fetch(16'd3, 0, 1'b1, 16'd4);
      fetch(16'd4, 0, 1'b0, 16'd0);
      @(negedge clk);
      do_reset();
      fetch(16'd3, 0, 1'b0, 16'd0);
      mid_reset(16'd1234);
      fetch(16'd5, 0, 1'b0, 16'd0);

      cur = 16'($urandom_range(0, NUM_ROWS - 1));
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      nxt = 16'($urandom_range(NUM_ROWS, 65535));
         else if (r < 3)  nxt = cur;
         else             nxt = 16'($urandom_range(0, NUM_ROWS - 1));
         fetch(cur, $urandom_range(0, 3), 1'($urandom_range(0, 1)), nxt);
         cur = nxt;
      end

      check("addr_idle_zero", addr_idle_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
